// File: rtl/iob_reg_pipe_vr.sv
`default_nettype none
// ============================================================================
// Module   : iob_reg_pipe_vr
// Brief    : DEPTH-stage valid/ready register pipeline with bubble collapsing,
//            clock enable, synchronous clear and an occupancy count.
// Revision : 1.0
// ============================================================================
module iob_reg_pipe_vr #(
    parameter int                 DATA_W  = 21,
    parameter int                 DEPTH   = 2,
    parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}},
    parameter int                 LEVEL_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               arst_n_i,
    input  logic               cke_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    input  logic [DATA_W-1:0]  in_data_i,
    output logic               in_ready_o,
    output logic               out_valid_o,
    output logic [DATA_W-1:0]  out_data_o,
    input  logic               out_ready_i,
    output logic [LEVEL_W-1:0] level_o
);

    logic [DEPTH-1:0]   r_valid;
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [LEVEL_W-1:0] r_level;

    logic [DEPTH-1:0]   w_ready;
    logic [DEPTH-1:0]   w_src_valid;
    logic [DATA_W-1:0]  w_src_data [DEPTH];
    logic               w_in_xfer;
    logic               w_out_xfer;

    // A stage may load when it is empty or anything downstream can move:
    // accumulated as an OR from the output side, so bubbles collapse.
    always_comb begin
        logic v_acc;
        v_acc   = out_ready_i;
        w_ready = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            v_acc      = v_acc | ~r_valid[i];
            w_ready[i] = v_acc;
        end
    end

    assign in_ready_o  = w_ready[0] & cke_i & ~rst_i & arst_n_i;
    assign out_valid_o = r_valid[DEPTH-1] & cke_i;
    assign out_data_o  = r_data[DEPTH-1];
    assign level_o     = r_level;

    assign w_in_xfer  = in_valid_i & in_ready_o;
    assign w_out_xfer = out_valid_o & out_ready_i & ~rst_i;

    always_comb begin
        w_src_valid[0] = w_in_xfer;
        w_src_data[0]  = in_data_i;
        for (int i = 1; i < DEPTH; i++) begin
            w_src_valid[i] = r_valid[i-1];
            w_src_data[i]  = r_data[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_valid <= '0;
            r_level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RST_VAL;
            end
        end else if (cke_i) begin
            if (rst_i) begin
                r_valid <= '0;
                r_level <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_data[i] <= RST_VAL;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_ready[i]) begin
                        r_valid[i] <= w_src_valid[i];
                        // Data only moves with a valid source, so idle (possibly X) input never lands.
                        if (w_src_valid[i]) begin
                            r_data[i] <= w_src_data[i];
                        end
                    end
                end
                if (w_in_xfer && !w_out_xfer) begin
                    r_level <= r_level + LEVEL_W'(1);
                end else if (w_out_xfer && !w_in_xfer) begin
                    r_level <= r_level - LEVEL_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/iob_reg_pipe_vr.md
Name: iob_reg_pipe_vr

Overview:
- Parametrised successor to the single enable/reset register.
- A DEPTH-stage valid/ready pipeline register chain. Each stage holds DATA_W bits plus a valid flag.
- Provides clock enable, synchronous clear and asynchronous active-low reset, with per-stage bubble collapsing and an occupancy count.
- Sits on datapaths between IOb peripherals and the core, where a registered stage must apply backpressure without losing data.

Parameters:
- DATA_W, 21, payload width in bits (>=1).
- DEPTH, 2, number of register stages (>=1).
- RST_VAL, {DATA_W{1'b0}}, value loaded into every stage data register on any reset or clear.
- LEVEL_W, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- arst_n_i  input  1  asynchronous reset, active-low.
- cke_i  input  1  clock enable; low freezes all state.
- rst_i  input  1  synchronous clear, active-high, qualified by cke_i.
- in_valid_i  input  1  upstream data valid.
- in_data_i  input  DATA_W  upstream payload.
- in_ready_o  output  1  pipeline can accept in_data_i this cycle.
- out_valid_o  output  1  last stage holds valid data.
- out_data_o  output  DATA_W  last stage data register, driven directly.
- out_ready_i  input  1  downstream accepts out_data_o.
- level_o  output  LEVEL_W  number of valid stages, 0..DEPTH.

Behaviour:
- Reset: while arst_n_i=0, immediately and regardless of clk_i/cke_i:
  - all valid flags = 0; all data registers = RST_VAL; level_o = 0;
  - therefore out_valid_o = 0, out_data_o = RST_VAL, in_ready_o = 0.
- Synchronous clear: at a rising edge with cke_i=1 and rst_i=1, same state as async reset. rst_i has priority over any handshake in that cycle.
  - While rst_i=1: in_ready_o = 0; out_valid_o still reflects current state, but no out transfer is counted.
- cke_i=0: no register changes. in_ready_o = 0 and out_valid_o = 0 (outputs masked), so no transfer can occur. Data registers keep their values.
- Transfers:
  - In transfer = in_valid_i & in_ready_o.
  - Out transfer = out_valid_o & out_ready_i.
  - Both are evaluated in the same cycle.
- Stage advance (stage 0 = input side, stage DEPTH-1 = output):
  - ready[DEPTH] = out_ready_i.
  - ready[i] = ~valid[i] | ready[i+1]. This chain is combinational; bubbles collapse.
  - in_ready_o = ready[0] & cke_i & ~rst_i.
  - Stage i loads from stage i-1 (or from in_data_i/in_valid_i for i=0) when ready[i]=1 and cke_i=1.
  - When a stage loads an invalid source, its valid flag clears and its data register is NOT updated (holds last value).
  - When ready[i]=0, stage i holds.
- Latency: data accepted at edge k is presented on out_data_o with out_valid_o=1 after edge k+DEPTH-1 when no stall occurs. For DEPTH=1 this is immediately after the accept edge.
- Throughput: one transfer per cycle sustained, with in and out transfers in the same cycle.
- Ordering: strictly FIFO; no drop, no duplication.
- level_o: registered counter.
  - +1 on in transfer only; -1 on out transfer only; unchanged when both or neither.
  - Cleared by reset/clear.
  - Always equals the popcount of the valid flags.
- Full (level_o=DEPTH) and out_ready_i=0: in_ready_o = 0, all stages hold.
- Full and out_ready_i=1: in_ready_o = 1 in the same cycle (pass-through of ready); level unchanged on a simultaneous in transfer.
- Empty (level_o=0): out_valid_o = 0; out_data_o holds the last delivered value (or RST_VAL after reset).
- out_data_o must not change while out_valid_o=1 and out_ready_i=0 (AXI-stream stability rule).
- Unknown/X on in_data_i while in_valid_i=0 must not propagate to out_data_o.

Test Plan:
- Reset: arst_n_i=0 mid-stream with DEPTH=2 holding 0x0AA, 0x0BB -> same cycle out_valid_o=0, out_data_o=RST_VAL, level_o=0, in_ready_o=0; after release, first accept of 0x123 appears at output after 1 further edge.
- Streaming: DEPTH=3, out_ready_i=1, send 1,2,3,...,10 back-to-back -> out_data_o sequence 1..10, first valid 2 edges after the first accept; level_o steady at 3 in mid-stream; in_ready_o never drops.
- Backpressure/fill: DEPTH=2, out_ready_i=0, offer 0x11, 0x22, 0x33 -> 0x11 and 0x22 accepted, in_ready_o=0 with 0x33 pending, level_o=2, out_data_o stable at 0x11; then out_ready_i=1 for 3 cycles -> outputs 0x11, 0x22, 0x33, level_o returns to 0.
- Bubble collapse: DEPTH=4, send one word then idle, stall the output -> word reaches stage 3; next word 0x55 lands behind it; level_o=2; no gap at output when released.
- Clock enable: cke_i=0 for 5 cycles with level_o=2 and out_ready_i=1 -> out_valid_o=0, in_ready_o=0, no state/level change; on cke_i=1, delivery resumes in order.
- Sync clear vs handshake: rst_i=1 with cke_i=1 coinciding with in_valid_i=1 and out_ready_i=1 at level_o=1 -> next state empty, level_o=0, data=RST_VAL, neither transfer counted.
